zmc_wb_timer: RTL

// - Wishbone slave timer/interrupt peripheral answering the zmc_top Wishbone master (wb_*_o/wb_*_i).
// - Drives the CPU interrupt request intr_h and consumes its acknowledge intr_ack_h.
// - Sits beside ram_wb on the same bus. Its decoded data output is zero when not selected, so it can be ORed into wb_dat_i.

---
 rtl/zmc_pkg.sv | 28 ++
 rtl/zmc_prescaler.sv | 38 +++
 rtl/zmc_wb_timer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/zmc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : zmc_pkg
// Brief   : Shared constants for the zmc Wishbone peripherals: bus widths,
//           timer register offsets and CTRL field positions.
// Revision: 1.0 - initial release
// ============================================================================
package zmc_pkg;

    // Bus widths (word addressed)
    localparam int ZMC_DW = 16;
    localparam int ZMC_AW = 16;

    // Timer register offsets within the 4-word window
    localparam logic [1:0] ZMC_TMR_CTRL   = 2'd0;
    localparam logic [1:0] ZMC_TMR_RELOAD = 2'd1;
    localparam logic [1:0] ZMC_TMR_COUNT  = 2'd2;
    localparam logic [1:0] ZMC_TMR_STATUS = 2'd3;

    // CTRL bit positions
    localparam int ZMC_CTRL_EN         = 0;
    localparam int ZMC_CTRL_AUTO       = 1;
    localparam int ZMC_CTRL_IE         = 2;
    localparam int ZMC_CTRL_PRESC_LSB  = 8;
    localparam int ZMC_CTRL_PRESC_MSB  = 15;

endpackage
`default_nettype wire

// File: rtl/zmc_prescaler.sv
`default_nettype none
// ============================================================================
// Module  : zmc_prescaler
// Brief   : Free-running 0..i_term counter that emits a one-cycle tick on the
//           terminal value; held at zero while disabled or cleared.
// Revision: 1.0 - initial release
// ============================================================================
module zmc_prescaler #(
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               a_reset_l,
    input  logic               i_en,
    input  logic               i_clr,
    input  logic [PRESC_W-1:0] i_term,
    output logic               o_tick
);

    logic [PRESC_W-1:0] r_cnt;
    logic               w_term_hit;

    assign w_term_hit = (r_cnt == i_term);
    // A clear takes priority so a fresh enable never inherits a stale tick
    assign o_tick     = i_en & ~i_clr & w_term_hit;

    // Count up to the terminal value, wrap, and stay at zero while idle
    always_ff @(posedge clk) begin
        if (!a_reset_l) begin
            r_cnt <= '0;
        end else if (i_clr || !i_en || w_term_hit) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/zmc_wb_timer.sv
`default_nettype none
// ============================================================================
// Module  : zmc_wb_timer
// Brief   : Wishbone slave down-counter timer with prescaler, auto-reload and
//           level interrupt. Read data is zero outside the ack cycle so it can
//           be ORed onto the shared read bus.
// Revision: 1.0 - initial release
// ============================================================================
module zmc_wb_timer
    import zmc_pkg::*;
#(
    parameter logic [15:0] BASE_ADR = 16'hFF00,
    parameter int          PRESC_W  = 8
) (
    input  logic              clk,
    input  logic              a_reset_l,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [ZMC_AW-1:0] wb_adr_i,
    input  logic [ZMC_DW-1:0] wb_dat_i,
    output logic [ZMC_DW-1:0] wb_dat_o,
    output logic              wb_ack_o,
    input  logic              intr_ack_h,
    output logic              intr_h
);

    localparam int c_presc_fw = ZMC_CTRL_PRESC_MSB - ZMC_CTRL_PRESC_LSB + 1;

    // Bus state
    logic              r_ack;
    logic [ZMC_DW-1:0] r_dat;

    // Register file
    logic               r_en;
    logic               r_auto;
    logic               r_ie;
    logic [PRESC_W-1:0] r_presc;
    logic [ZMC_DW-1:0]  r_reload;
    logic [ZMC_DW-1:0]  r_count;
    logic               r_exp;
    logic               r_intr;

    // Decode and event wires
    logic              w_sel;
    logic              w_acc;
    logic              w_wr_ctrl;
    logic              w_wr_reload;
    logic              w_wr_status;
    logic              w_en_rise;
    logic              w_tick;
    logic              w_expire;
    logic              w_exp_clr;
    logic [c_presc_fw-1:0] w_presc_rd;
    logic [ZMC_DW-1:0] w_rdata;

    assign w_sel = wb_cyc_i & wb_stb_i & (wb_adr_i[15:2] == BASE_ADR[15:2]);
    // An access commits on the edge that raises ack, never on the drop cycle
    assign w_acc = w_sel & ~r_ack;

    assign w_wr_ctrl   = w_acc & wb_we_i & (wb_adr_i[1:0] == ZMC_TMR_CTRL);
    assign w_wr_reload = w_acc & wb_we_i & (wb_adr_i[1:0] == ZMC_TMR_RELOAD);
    assign w_wr_status = w_acc & wb_we_i & (wb_adr_i[1:0] == ZMC_TMR_STATUS);

    assign w_en_rise = w_wr_ctrl & wb_dat_i[ZMC_CTRL_EN] & ~r_en;
    assign w_expire  = w_tick & (r_count == '0);
    assign w_exp_clr = intr_ack_h | (w_wr_status & wb_dat_i[0]);

    generate
        if (PRESC_W < c_presc_fw) begin : g_presc_pad
            assign w_presc_rd = {{(c_presc_fw - PRESC_W){1'b0}}, r_presc};
        end else begin : g_presc_full
            assign w_presc_rd = r_presc[c_presc_fw-1:0];
        end
    endgenerate

    zmc_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_presc (
        .clk       (clk),
        .a_reset_l (a_reset_l),
        .i_en      (r_en),
        .i_clr     (w_en_rise),
        .i_term    (r_presc),
        .o_tick    (w_tick)
    );

    // Read multiplexer over the four register words
    always_comb begin
        w_rdata = '0;
        case (wb_adr_i[1:0])
            ZMC_TMR_CTRL:   w_rdata = {w_presc_rd, 5'b0, r_ie, r_auto, r_en};
            ZMC_TMR_RELOAD: w_rdata = r_reload;
            ZMC_TMR_COUNT:  w_rdata = r_count;
            ZMC_TMR_STATUS: w_rdata = {15'b0, r_exp};
            default:        w_rdata = '0;
        endcase
    end

    // Single-cycle ack with registered read data, zero outside the ack cycle
    always_ff @(posedge clk) begin
        if (!a_reset_l) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_acc;
            r_dat <= (w_acc && !wb_we_i) ? w_rdata : '0;
        end
    end

    // CTRL and RELOAD registers; a one-shot expiry overrides a same-cycle write
    always_ff @(posedge clk) begin
        if (!a_reset_l) begin
            r_en     <= 1'b0;
            r_auto   <= 1'b0;
            r_ie     <= 1'b0;
            r_presc  <= '0;
            r_reload <= 16'hFFFF;
        end else begin
            if (w_wr_ctrl) begin
                r_en    <= wb_dat_i[ZMC_CTRL_EN];
                r_auto  <= wb_dat_i[ZMC_CTRL_AUTO];
                r_ie    <= wb_dat_i[ZMC_CTRL_IE];
                r_presc <= wb_dat_i[ZMC_CTRL_PRESC_LSB +: PRESC_W];
            end
            if (w_expire && !r_auto) begin
                r_en <= 1'b0;
            end
            if (w_wr_reload) begin
                r_reload <= wb_dat_i;
            end
        end
    end

    // Down-counter: load on enable, decrement per tick, reload or park at zero
    always_ff @(posedge clk) begin
        if (!a_reset_l) begin
            r_count <= '0;
        end else if (w_en_rise) begin
            r_count <= r_reload;
        end else if (w_tick) begin
            if (r_count != '0) begin
                r_count <= r_count - 1'b1;
            end else if (r_auto) begin
                r_count <= r_reload;
            end
        end
    end

    // Expiry flag (set beats clear) and the registered interrupt level
    always_ff @(posedge clk) begin
        if (!a_reset_l) begin
            r_exp  <= 1'b0;
            r_intr <= 1'b0;
        end else begin
            if (w_expire) begin
                r_exp <= 1'b1;
            end else if (w_exp_clr) begin
                r_exp <= 1'b0;
            end
            r_intr <= r_exp & r_ie;
        end
    end

    assign wb_ack_o = r_ack;
    assign wb_dat_o = r_dat;
    assign intr_h   = r_intr;

endmodule
`default_nettype wire
